pmem_line_arbiter: RTL and testbench

- Sits directly downstream of the I-cache and D-cache controllers.
- Merges their cacheline miss/writeback requests onto the single shared physical-memory port, which drives the cacheline adaptor.
- Grants one client at a time and latches the line address and write data for the duration of the transaction.
- Routes pmem_resp and read data back to the granted client only, and keeps saturating per-client grant counters for performance accounting.

---
 rtl/pmem_line_arbiter_pkg.sv | 18 +
 rtl/pmem_line_arbiter_sat_counter.sv | 20 ++
 rtl/pmem_line_arbiter.sv | 133 +++++++++++++
 tb/tb_pmem_line_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_line_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter onto the single pmem port.
// Client and FSM encodings plus the cacheline offset width.
package pmem_arb_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        CLIENT_I,
        CLIENT_D
    } arb_client_t;

    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/pmem_line_arbiter_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Used for per-client completed-transaction accounting.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pmem_line_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line requests onto
// one pmem port; address/wdata/op are latched for the whole transaction.
module pmem_line_arbiter
    import pmem_arb_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    arb_state_t        state, state_next;
    arb_client_t       last_grant, last_grant_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [LINE_W-1:0] wdata_q, wdata_next;
    logic              write_q, write_next;
    logic              i_req, d_req;
    logic              serve_i, serve_d;
    logic              i_done, d_done;

    function automatic logic [ADDR_W-1:0] align(
        input logic [ADDR_W-1:0] a
    );
        return {a[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    endfunction

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= CLIENT_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            write_q    <= write_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        write_next      = write_q;
        unique case (state)
            IDLE: begin
                // I wins unless D also asks and I was served last
                if (i_req && (!d_req || last_grant == CLIENT_D)) begin
                    state_next      = SERVE_I;
                    last_grant_next = CLIENT_I;
                    addr_next       = align(i_pmem_address);
                    wdata_next      = d_pmem_wdata;
                    write_next      = 1'b0;
                end else if (d_req) begin
                    state_next      = SERVE_D;
                    last_grant_next = CLIENT_D;
                    addr_next       = align(d_pmem_address);
                    wdata_next      = d_pmem_wdata;
                    write_next      = d_pmem_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign serve_i = (state == SERVE_I);
    assign serve_d = (state == SERVE_D);
    assign i_done  = serve_i & pmem_resp;
    assign d_done  = serve_d & pmem_resp;

    assign pmem_read    = serve_i | (serve_d & ~write_q);
    assign pmem_write   = serve_d & write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = i_done;
    assign d_pmem_resp  = d_done;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_done),
        .count (i_grant_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_done),
        .count (d_grant_cnt)
    );

    // simultaneous D read+write is a client bug; write wins in the FSM
    a_d_rw_excl: assert property (
        @(posedge clk) disable iff (!rst)
        !(d_pmem_read && d_pmem_write)
    );

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Self-checking bench for pmem_line_arbiter: vector table, directed
// corner sequences, and a random run against a transaction-level model.
module tb_pmem_line_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic [CW-1:0] i_grant_cnt;
    logic [CW-1:0] d_grant_cnt;

    int errors = 0;
    int checks = 0;

    pmem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .i_grant_cnt    (i_grant_cnt),
        .d_grant_cnt    (d_grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          i_rd;
        bit          d_rd;
        bit          d_wr;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic [31:0] wd;
        bit          exp_d;
        logic [31:0] exp_addr;
        bit          exp_rd;
        bit          exp_wr;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
        pmem_resp = 0;
        #12;
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic run_txn(input bit is_d, input bit wr,
                           input logic [31:0] addr,
                           input logic [LW-1:0] rd);
        bit g = 0;
        if (is_d) begin
            d_pmem_read = !wr; d_pmem_write = wr; d_pmem_address = addr;
        end else begin
            i_pmem_read = 1; i_pmem_address = addr;
        end
        for (int k = 0; k < 20 && !g; k++) begin
            tick();
            g = pmem_read | pmem_write;
        end
        chk("txn_grant", g, 1);
        pmem_rdata = rd;
        pmem_resp = 1;
        #1;
        chk("txn_resp", is_d ? d_pmem_resp : i_pmem_resp, 1);
        tick();
        pmem_resp = 0;
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] r;
        logic [LW-1:0] w;
        int order[$];
        bit ih, dh;
        int m_busy, m_last, m_icnt, m_dcnt, icool, dcool, dly;
        logic [31:0] m_addr, ia, da;
        logic [LW-1:0] m_wdata, dw, rd;
        bit m_wr, ir, drd, dwr, resp;

        tbl[0] = '{1, 0, 0, 32'h0000_1234, 32'h0, 32'h11, 0, 32'h0000_1220, 1, 0};
        tbl[1] = '{1, 0, 1, 32'h0000_0040, 32'h8F, 32'hA5A5_0001, 1, 32'h0000_0080, 0, 1};
        tbl[2] = '{1, 1, 0, 32'h0001_001F, 32'h2000, 32'h22, 0, 32'h0001_0000, 1, 0};
        tbl[3] = '{0, 1, 0, 32'h0, 32'hFFFF_FFFF, 32'h33, 1, 32'hFFFF_FFE0, 1, 0};
        tbl[4] = '{1, 0, 1, 32'hABCD_EF01, 32'h300, 32'h44, 0, 32'hABCD_EF00, 1, 0};
        tbl[5] = '{1, 0, 0, 32'h0000_003F, 32'h0, 32'h55, 0, 32'h0000_0020, 1, 0};
        tbl[6] = '{1, 0, 1, 32'h0000_0500, 32'h61F, 32'h5A5A_0002, 1, 32'h0000_0600, 0, 1};
        tbl[7] = '{0, 0, 1, 32'h0, 32'h20, 32'h7777_0003, 1, 32'h0000_0020, 0, 1};
        tbl[8] = '{1, 1, 0, 32'h0000_07FF, 32'h800, 32'h88, 0, 32'h0000_07E0, 1, 0};

        // reset values
        rst = 1'b0;
        #3;
        chk("rst_read", pmem_read, 0);
        chk("rst_write", pmem_write, 0);
        chk("rst_iresp", i_pmem_resp, 0);
        chk("rst_dresp", d_pmem_resp, 0);
        chk("rst_icnt", i_grant_cnt, 0);
        chk("rst_dcnt", d_grant_cnt, 0);
        do_reset();

        // I-only read, response after 4 serve cycles
        i_pmem_read = 1; i_pmem_address = 32'h0000_1234;
        #1;
        chk("a_latency", pmem_read, 0);
        tick();
        chk("a_read", pmem_read, 1);
        chk("a_addr", pmem_address, 32'h0000_1220);
        r = rnd_line();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                pmem_resp = 1; pmem_rdata = r;
            end
            #1;
            chk("a_iresp", i_pmem_resp, (k == 3));
            chk("a_dresp", d_pmem_resp, 0);
            if (k == 3) chk("a_rdata", i_pmem_rdata, r);
            tick();
        end
        pmem_resp = 0; i_pmem_read = 0;
        #1;
        chk("a_icnt", i_grant_cnt, 1);
        chk("a_iresp_low", i_pmem_resp, 0);
        tick();

        // vector table: grant choice, alignment, op, latched data
        do_reset();
        foreach (tbl[n]) begin
            i_pmem_read = tbl[n].i_rd;
            i_pmem_address = tbl[n].i_addr;
            d_pmem_read = tbl[n].d_rd;
            d_pmem_write = tbl[n].d_wr;
            d_pmem_address = tbl[n].d_addr;
            d_pmem_wdata = {8{tbl[n].wd}};
            tick();
            chk("t_read", pmem_read, tbl[n].exp_rd);
            chk("t_write", pmem_write, tbl[n].exp_wr);
            chk("t_addr", pmem_address, tbl[n].exp_addr);
            if (tbl[n].exp_wr) chk("t_wdata", pmem_wdata, {8{tbl[n].wd}});
            i_pmem_address = 32'hDEAD_BEEF;
            d_pmem_address = 32'hBEEF_DEAD;
            d_pmem_wdata = rnd_line();
            r = rnd_line();
            pmem_rdata = r;
            pmem_resp = 1;
            #1;
            chk("t_iresp", i_pmem_resp, !tbl[n].exp_d);
            chk("t_dresp", d_pmem_resp, tbl[n].exp_d);
            chk("t_rdata", tbl[n].exp_d ? d_pmem_rdata : i_pmem_rdata, r);
            tick();
            pmem_resp = 0;
            i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
            tick();
        end
        chk("t_icnt", i_grant_cnt, 5);
        chk("t_dcnt", d_grant_cnt, 4);

        // simultaneous I read + D write; one idle cycle; D latches hold
        do_reset();
        w = rnd_line();
        i_pmem_read = 1; i_pmem_address = 32'h0000_0100;
        d_pmem_write = 1; d_pmem_address = 32'h0000_2005; d_pmem_wdata = w;
        tick();
        chk("b_i_first", pmem_read, 1);
        chk("b_i_nowr", pmem_write, 0);
        chk("b_i_addr", pmem_address, 32'h0000_0100);
        pmem_resp = 1;
        #1;
        chk("b_iresp", i_pmem_resp, 1);
        chk("b_dresp0", d_pmem_resp, 0);
        tick();
        pmem_resp = 0; i_pmem_read = 0;
        #1;
        chk("b_idle_rd", pmem_read, 0);
        chk("b_idle_wr", pmem_write, 0);
        tick();
        chk("b_d_write", pmem_write, 1);
        chk("b_d_addr", pmem_address, 32'h0000_2000);
        chk("b_d_wdata", pmem_wdata, w);
        d_pmem_address = 32'hDEAD_0000; d_pmem_wdata = ~w;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("b_hold_addr", pmem_address, 32'h0000_2000);
            chk("b_hold_wdata", pmem_wdata, w);
            chk("b_hold_wr", pmem_write, 1);
        end
        pmem_resp = 1;
        #1;
        chk("b_dresp", d_pmem_resp, 1);
        chk("b_iresp0", i_pmem_resp, 0);
        tick();
        pmem_resp = 0; d_pmem_write = 0;
        tick();

        // continuous requests alternate I, D, I, D, I, D
        do_reset();
        i_pmem_read = 1; d_pmem_read = 1;
        for (int c = 0; c < 100 && order.size() < 6; c++) begin
            pmem_resp = pmem_read | pmem_write;
            #1;
            ih = i_pmem_resp; dh = d_pmem_resp;
            if (ih) order.push_back(1);
            if (dh) order.push_back(2);
            tick();
            pmem_resp = 0;
            i_pmem_read = !ih; d_pmem_read = !dh;
        end
        i_pmem_read = 0; d_pmem_read = 0;
        chk("c_count", order.size(), 6);
        for (int k = 0; k < 6; k++)
            chk("c_order", (k < order.size()) ? order[k] : 0, (k % 2) + 1);
        tick();
        chk("c_icnt", i_grant_cnt, 3);
        chk("c_dcnt", d_grant_cnt, 3);

        // asynchronous reset mid SERVE_I, late resp ignored
        do_reset();
        i_pmem_read = 1; i_pmem_address = 32'h40;
        tick();
        chk("r_serving", pmem_read, 1);
        #2 rst = 0; i_pmem_read = 0;
        #1;
        chk("r_async_rd", pmem_read, 0);
        #2 rst = 1;
        tick();
        pmem_resp = 1;
        #1;
        chk("r_late_iresp", i_pmem_resp, 0);
        chk("r_late_dresp", d_pmem_resp, 0);
        chk("r_late_rd", pmem_read, 0);
        tick();
        pmem_resp = 0;
        chk("r_icnt", i_grant_cnt, 0);
        chk("r_dcnt", d_grant_cnt, 0);

        // counter saturation at 4'hF
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            run_txn(1, 0, 32'h1000 + 32'(n * 32), rnd_line());
            if (n == 8) chk("s_dcnt8", d_grant_cnt, 8);
            if (n == 15) chk("s_dcnt15", d_grant_cnt, 15);
        end
        chk("s_dcnt_sat", d_grant_cnt, 15);
        chk("s_icnt", i_grant_cnt, 0);

        // random run against a transaction-level model
        do_reset();
        m_busy = 0; m_last = 2; m_icnt = 0; m_dcnt = 0;
        icool = 0; dcool = 0; dly = 0; m_wr = 0;
        m_addr = 0; m_wdata = 0;
        ir = 0; drd = 0; dwr = 0; ia = 0; da = 0; dw = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!ir && icool == 0 && m_busy != 1 && $urandom_range(0, 3) == 0) begin
                ir = 1; ia = $urandom;
            end
            if (!drd && !dwr && dcool == 0 && m_busy != 2 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) dwr = 1;
                else drd = 1;
                da = $urandom; dw = rnd_line();
            end
            if (m_busy != 0 && $urandom_range(0, 4) == 0) begin
                ia = $urandom; da = $urandom; dw = rnd_line();
            end
            if (m_busy == 1 && $urandom_range(0, 9) == 0) ir = 0;
            if (m_busy == 2 && $urandom_range(0, 9) == 0) begin
                drd = 0; dwr = 0;
            end
            if (m_busy != 0) resp = (dly == 0);
            else resp = ($urandom_range(0, 7) == 0);
            rd = rnd_line();
            i_pmem_read = ir; i_pmem_address = ia;
            d_pmem_read = drd; d_pmem_write = dwr;
            d_pmem_address = da; d_pmem_wdata = dw;
            pmem_resp = resp; pmem_rdata = rd;
            #1;
            chk("m_read", pmem_read, m_busy == 1 || (m_busy == 2 && !m_wr));
            chk("m_write", pmem_write, m_busy == 2 && m_wr);
            if (m_busy != 0) chk("m_addr", pmem_address, m_addr);
            if (m_busy == 2 && m_wr) chk("m_wdata", pmem_wdata, m_wdata);
            chk("m_iresp", i_pmem_resp, m_busy == 1 && resp);
            chk("m_dresp", d_pmem_resp, m_busy == 2 && resp);
            chk("m_irdata", i_pmem_rdata, rd);
            chk("m_drdata", d_pmem_rdata, rd);
            chk("m_icnt", i_grant_cnt, m_icnt);
            chk("m_dcnt", d_grant_cnt, m_dcnt);
            ih = (m_busy == 1) && resp;
            dh = (m_busy == 2) && resp;
            if (ih) begin
                if (m_icnt < 15) m_icnt++;
                ir = 0; icool = 1;
            end else if (icool > 0) icool--;
            if (dh) begin
                if (m_dcnt < 15) m_dcnt++;
                drd = 0; dwr = 0; dcool = 1;
            end else if (dcool > 0) dcool--;
            if (m_busy != 0) begin
                if (resp) m_busy = 0;
                else dly--;
            end else if (i_pmem_read && (!(d_pmem_read || d_pmem_write) || m_last == 2)) begin
                m_busy = 1; m_last = 1; m_wr = 0;
                m_addr = i_pmem_address & ~32'h1F;
                dly = $urandom_range(0, 3);
            end else if (d_pmem_read || d_pmem_write) begin
                m_busy = 2; m_last = 2; m_wr = d_pmem_write;
                m_addr = d_pmem_address & ~32'h1F;
                m_wdata = d_pmem_wdata;
                dly = $urandom_range(0, 3);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
